// File: rtl/mask_generation_param.sv
`default_nettype none
// ============================================================================
// Module      : mask_generation_param
// Description : Builds one COLS-wide pixel mask row per request, either from a
//               serially loaded sliding pattern or from a 32-bit Galois LFSR.
//               Optional row/frame counting is enabled by MG_ROW_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mask_generation_param #(
    parameter int          COLS    = 640,
    parameter int          PAT_MAX = 32,
    parameter int          LFSR_W  = 32,
    parameter logic [31:0] SEED    = 32'hACE1_2468,
`ifdef MG_ROW_COUNT_EN
    parameter int          ROWS    = 480,
    localparam int         RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
`endif
    localparam int         PW      = $clog2(PAT_MAX)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic [PW-1:0]   pattern_w,
    input  logic            pattern,
    input  logic            load_pattern,
    input  logic            right_sliding,
    input  logic            mask_type,
    input  logic            row_req,
    input  logic            mg_ready,
`ifdef MG_ROW_COUNT_EN
    output logic [RW-1:0]   mg_row_idx,
    output logic            mg_frame_end,
`endif
    output logic [COLS-1:0] mg_mask,
    output logic [COLS-1:0] mg_mask_n,
    output logic            mg_valid,
    output logic            busy
);

    localparam int          NCH       = COLS / LFSR_W;
    localparam int          CW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [PW:0] PAT_MAX_V = (PW+1)'(PAT_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_GEN_RP  = 3'd2,
        S_GEN_RND = 3'd3,
        S_VALID   = 3'd4
    } state_t;

    state_t            state_q,   state_d;
    logic [PAT_MAX-1:0] pat_q,    pat_d;
    logic [PW:0]       bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]     offset_q,  offset_d;
    logic [31:0]       lfsr_q,    lfsr_d;
    logic [CW-1:0]     chunk_q,   chunk_d;
    logic              mode_q,    mode_d;
    logic [COLS-1:0]   mask_q,    mask_d;
    logic              valid_q,   valid_d;
    logic              seen_q,    seen_d;
`ifdef MG_ROW_COUNT_EN
    logic [RW-1:0]     row_idx_q, row_idx_d;
`endif

    logic [PW:0]        w_len;
    logic [PW-1:0]      eff_off;
    logic [PW:0]        rot_idx;
    logic [PAT_MAX-1:0] rot_pat;
    logic [COLS-1:0]    rp_row;
    logic [31:0]        lfsr_step;

    // Advance the Galois LFSR by LFSR_W single steps in one cycle.
    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int k = 0; k < LFSR_W; k++) begin
            r = r[0] ? ((r >> 1) ^ LFSR_TAPS) : (r >> 1);
        end
        return r;
    endfunction

    assign w_len   = {1'b0, pattern_w} + {{PW{1'b0}}, 1'b1};
    // A stale offset left over from a longer pattern restarts at column phase 0.
    assign eff_off = ({1'b0, offset_q} >= w_len) ? '0 : offset_q;

    always_comb begin
        rot_pat = '0;
        rot_idx = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            rot_idx = (PW+1)'(i) + {1'b0, eff_off};
            if (rot_idx >= w_len) begin
                rot_idx = rot_idx - w_len;
            end
            if ((PW+1)'(i) < w_len) begin
                rot_pat[i] = pat_q[rot_idx[PW-1:0]];
            end
        end
    end

    // Column c takes rot_pat[c mod W]; with c and W both loop constants each
    // column reduces to a plain mux selected by pattern_w.
    always_comb begin
        rp_row = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int w = 1; w <= PAT_MAX; w++) begin
                if (pattern_w == PW'(w - 1)) begin
                    rp_row[c] = rot_pat[PW'(c % w)];
                end
            end
        end
    end

    assign lfsr_step = lfsr_adv(lfsr_q);

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        bit_cnt_d = bit_cnt_q;
        offset_d  = offset_q;
        lfsr_d    = lfsr_q;
        chunk_d   = chunk_q;
        mode_d    = mode_q;
        mask_d    = mask_q;
        valid_d   = valid_q;
        seen_d    = seen_q;
`ifdef MG_ROW_COUNT_EN
        row_idx_d = row_idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_pattern) begin
                    state_d   = S_LOAD;
                    pat_d     = '0;
                    pat_d[0]  = pattern;
                    bit_cnt_d = (PW+1)'(1);
                    offset_d  = '0;
                end else if (row_req) begin
                    mode_d  = mask_type;
                    chunk_d = '0;
                    state_d = mask_type ? S_GEN_RND : S_GEN_RP;
                end
            end
            S_LOAD: begin
                if (load_pattern) begin
                    if (bit_cnt_q < PAT_MAX_V) begin
                        pat_d[bit_cnt_q[PW-1:0]] = pattern;
                        bit_cnt_d = bit_cnt_q + (PW+1)'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GEN_RP: begin
                mask_d  = rp_row;
                valid_d = 1'b1;
                seen_d  = 1'b1;
                state_d = S_VALID;
            end
            S_GEN_RND: begin
                lfsr_d = lfsr_step;
                for (int k = 0; k < NCH; k++) begin
                    if (chunk_q == CW'(k)) begin
                        mask_d[k*LFSR_W +: LFSR_W] = lfsr_step[LFSR_W-1:0];
                    end
                end
                if (chunk_q == CW'(NCH - 1)) begin
                    valid_d = 1'b1;
                    seen_d  = 1'b1;
                    state_d = S_VALID;
                end else begin
                    chunk_d = chunk_q + CW'(1);
                end
            end
            S_VALID: begin
                if (mg_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    if (!mode_q) begin
                        if (right_sliding) begin
                            offset_d = (eff_off == '0) ? pattern_w : eff_off - PW'(1);
                        end else begin
                            offset_d = (eff_off == pattern_w) ? '0 : eff_off + PW'(1);
                        end
                    end
`ifdef MG_ROW_COUNT_EN
                    // Frame wrap restarts both generators so every frame repeats.
                    if (row_idx_q == RW'(ROWS - 1)) begin
                        row_idx_d = '0;
                        offset_d  = '0;
                        lfsr_d    = SEED;
                    end else begin
                        row_idx_d = row_idx_q + RW'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            bit_cnt_q <= '0;
            offset_q  <= '0;
            lfsr_q    <= SEED;
            chunk_q   <= '0;
            mode_q    <= 1'b0;
            mask_q    <= '0;
            valid_q   <= 1'b0;
            seen_q    <= 1'b0;
`ifdef MG_ROW_COUNT_EN
            row_idx_q <= '0;
`endif
        end else if (clk_en) begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            bit_cnt_q <= bit_cnt_d;
            offset_q  <= offset_d;
            lfsr_q    <= lfsr_d;
            chunk_q   <= chunk_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            seen_q    <= seen_d;
`ifdef MG_ROW_COUNT_EN
            row_idx_q <= row_idx_d;
`endif
        end
    end

    assign mg_mask   = mask_q;
    assign mg_mask_n = seen_q ? ~mask_q : '0;
    assign mg_valid  = valid_q;
    assign busy      = (state_q != S_IDLE);
`ifdef MG_ROW_COUNT_EN
    assign mg_row_idx   = row_idx_q;
    assign mg_frame_end = (state_q == S_VALID) && (row_idx_q == RW'(ROWS - 1));
`endif

endmodule
`default_nettype wire

// File: tb/tb_mask_generation_param.sv
`default_nettype none
// Testbench for mask_generation_param: scoreboard of expected rows pushed at
// request time and compared when mg_valid rises.
module tb_mask_generation_param;

    localparam int          COLS    = 640;
    localparam int          PAT_MAX = 32;
    localparam int          PW      = 5;
    localparam int          LFSR_W  = 32;
    localparam logic [31:0] SEED    = 32'hACE1_2468;

    logic            clk = 1'b0;
    logic            rst_n, clk_en, pattern, load_pattern, right_sliding;
    logic            mask_type, row_req, mg_ready;
    logic [PW-1:0]   pattern_w;
    logic [COLS-1:0] mg_mask, mg_mask_n;
    logic            mg_valid, busy;
`ifdef MG_ROW_COUNT_EN
    logic [8:0]      mg_row_idx;
    logic            mg_frame_end;
`endif

    mask_generation_param #(
        .COLS    (COLS),
        .PAT_MAX (PAT_MAX),
        .LFSR_W  (LFSR_W),
        .SEED    (SEED)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .pattern_w     (pattern_w),
        .pattern       (pattern),
        .load_pattern  (load_pattern),
        .right_sliding (right_sliding),
        .mask_type     (mask_type),
        .row_req       (row_req),
        .mg_ready      (mg_ready),
`ifdef MG_ROW_COUNT_EN
        .mg_row_idx    (mg_row_idx),
        .mg_frame_end  (mg_frame_end),
`endif
        .mg_mask       (mg_mask),
        .mg_mask_n     (mg_mask_n),
        .mg_valid      (mg_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int              checks   = 0;
    int              failures = 0;
    logic [COLS-1:0] exp_q[$];
    logic [PAT_MAX-1:0] m_pat;
    int              m_w;
    int              m_off;
    logic [31:0]     m_lfsr;
    logic [COLS-1:0] last_mask;
    logic [COLS-1:0] rnd_first;

    task automatic check_eq(input string tag, input logic [COLS-1:0] got,
                            input logic [COLS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COLS-1:0] rp_model(input logic [PAT_MAX-1:0] p,
                                                  input int w, input int off);
        logic [COLS-1:0] r;
        int o;
        o = (off >= w) ? 0 : off;
        for (int c = 0; c < COLS; c++) r[c] = p[(c + o) % w];
        return r;
    endfunction

    function automatic logic [31:0] lfsr_one(input logic [31:0] s);
        return (s >> 1) ^ ({32{s[0]}} & 32'h8020_0003);
    endfunction

    task automatic load(input int w, input logic [PAT_MAX-1:0] bits);
        pattern_w = PW'(w - 1);
        for (int i = 0; i < w; i++) begin
            load_pattern = 1'b1;
            pattern      = bits[i];
            step();
            if (i == 0) check_eq("busy_in_load", COLS'(busy), COLS'(1));
        end
        load_pattern = 1'b0;
        pattern      = 1'b0;
        step();
        m_pat = bits;
        m_w   = w;
        m_off = 0;
    endtask

    task automatic do_row(input logic mtype, input int ready_delay,
                          input bit toggle_en, input bit check_lat);
        logic [COLS-1:0] e;
        int n;
        int eff;
        e = '0;
        if (!mtype) begin
            e = rp_model(m_pat, m_w, m_off);
        end else begin
            for (int k = 0; k < COLS / LFSR_W; k++) begin
                for (int s = 0; s < LFSR_W; s++) m_lfsr = lfsr_one(m_lfsr);
                e[k*LFSR_W +: LFSR_W] = m_lfsr[LFSR_W-1:0];
            end
        end
        exp_q.push_back(e);
        mask_type = mtype;
        row_req   = 1'b1;
        step();
        row_req = 1'b0;
        n = 1;
        while (!mg_valid && n < 200) begin
            clk_en = toggle_en ? ~clk_en : 1'b1;
            step();
            n++;
        end
        clk_en = 1'b1;
        e = exp_q.pop_front();
        if (!mg_valid) begin
            check_eq("valid_timeout", COLS'(mg_valid), COLS'(1));
            return;
        end
        if (check_lat) check_eq("latency", COLS'(n), COLS'(mtype ? 21 : 2));
        last_mask = mg_mask;
        check_eq(mtype ? "rnd_mask" : "rp_mask", mg_mask, e);
        check_eq("mask_n", mg_mask_n, ~e);
        if (ready_delay > 0) begin
            repeat (ready_delay) step();
            check_eq("held_mask", mg_mask, e);
            check_eq("held_valid", COLS'(mg_valid), COLS'(1));
        end
        mg_ready = 1'b1;
        step();
        mg_ready = 1'b0;
        check_eq("valid_drop", COLS'(mg_valid), COLS'(0));
        if (!mtype) begin
            eff = (m_off >= m_w) ? 0 : m_off;
            if (right_sliding) m_off = (eff == 0) ? m_w - 1 : eff - 1;
            else               m_off = (eff == m_w - 1) ? 0 : eff + 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; pattern_w = '0; pattern = 1'b0;
        load_pattern = 1'b0; right_sliding = 1'b0; mask_type = 1'b0;
        row_req = 1'b0; mg_ready = 1'b0;
        m_lfsr = SEED; m_pat = '0; m_w = 1; m_off = 0;
        last_mask = '0; rnd_first = '0;
        repeat (2) step();
        check_eq("rst_mask", mg_mask, '0);
        check_eq("rst_mask_n", mg_mask_n, '0);
        check_eq("rst_valid", COLS'(mg_valid), COLS'(0));
        check_eq("rst_busy", COLS'(busy), COLS'(0));
        rst_n = 1'b1;
        step();

        // W=4 pattern 1,0,0,0 sliding left across five rows
        load(4, 32'h1);
        check_eq("mask_n_before_row", mg_mask_n, '0);
        right_sliding = 1'b0;
        do_row(1'b0, 0, 1'b0, 1'b1);
        check_eq("row0_literal", last_mask, {160{4'h1}});
        for (int r = 1; r < 5; r++) begin
            do_row(1'b0, 0, 1'b0, 1'b0);
            if (r == 1) check_eq("row1_literal", last_mask, {160{4'h8}});
            if (r == 4) check_eq("row4_wrap_literal", last_mask, {160{4'h1}});
        end

        // Right sliding from offset 0
        load(4, 32'h1);
        right_sliding = 1'b1;
        do_row(1'b0, 0, 1'b0, 1'b0);
        do_row(1'b0, 0, 1'b0, 1'b0);
        check_eq("right_off3_literal", last_mask, {160{4'h2}});

        // Random rows: held output, then clk_en toggling
        do_row(1'b1, 10, 1'b0, 1'b1);
        rnd_first = last_mask;
        do_row(1'b1, 0, 1'b1, 1'b0);
        // Offset must survive the random rows
        do_row(1'b0, 0, 1'b0, 1'b0);

        // W=1 constant row
        load(1, 32'h1);
        do_row(1'b0, 0, 1'b0, 1'b0);
        check_eq("w1_all_ones", last_mask, {COLS{1'b1}});

        // Offset beyond a shrunk pattern restarts at phase 0
        load(4, 32'h6);
        right_sliding = 1'b0;
        do_row(1'b0, 0, 1'b0, 1'b0);
        do_row(1'b0, 0, 1'b0, 1'b0);
        pattern_w = PW'(1);
        m_w = 2;
        do_row(1'b0, 0, 1'b0, 1'b0);
        check_eq("shrink_off0_literal", last_mask, {160{4'hA}});
        do_row(1'b0, 0, 1'b0, 1'b0);
        check_eq("shrink_off1_literal", last_mask, {160{4'h5}});

        // Reset during random chunk 7
        mask_type = 1'b1;
        row_req   = 1'b1;
        step();
        row_req = 1'b0;
        repeat (7) step();
        check_eq("abort_no_valid_pre", COLS'(mg_valid), COLS'(0));
        rst_n = 1'b0;
        repeat (2) step();
        check_eq("abort_valid", COLS'(mg_valid), COLS'(0));
        check_eq("abort_busy", COLS'(busy), COLS'(0));
        check_eq("abort_mask", mg_mask, '0);
        check_eq("abort_mask_n", mg_mask_n, '0);
        rst_n = 1'b1;
        step();
        m_lfsr = SEED; m_pat = '0; m_off = 0;
        do_row(1'b1, 0, 1'b0, 1'b1);
        check_eq("rnd_after_reset_first", last_mask, rnd_first);

        check_eq("sb_empty", COLS'(exp_q.size()), COLS'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
